// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//
// General-purpose register file for the five-stage pipeline. It has two
// combinational read ports with same-cycle write-to-read bypass, and an
// integrated pending-write scoreboard so ID can spot RAW hazards against
// producers that are still in flight.
//
// Parameters
//   DATA_WIDTH  register width in bits
//   DEPTH       number of architectural registers (2 .. 2**ADDR_WIDTH)
//   ADDR_WIDTH  register address width
//   ZERO_REG    1: register 0 reads 0, ignores writes and is never pending
//
// Ports
//   Clk            pipeline clock, rising edge
//   Reset_n        asynchronous active-low reset (clears data, pending, count)
//   ReadRegister1  read port 1 address
//   ReadRegister2  read port 2 address
//   ReadData1      read port 1 data (combinational, bypassed)
//   ReadData2      read port 2 data (combinational, bypassed)
//   ReadPending1   register at ReadRegister1 awaits an unretired write
//   ReadPending2   register at ReadRegister2 awaits an unretired write
//   Hazard         ReadPending1 | ReadPending2
//   WriteRegister  writeback destination
//   WriteData      writeback data
//   RegWrite       writeback enable
//   IssueValid     an instruction with a destination leaves ID this cycle
//   IssueRegister  destination of the issuing instruction
//   PendingCount   number of registers currently pending (registered)
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic [ADDR_WIDTH-1:0] ReadRegister1,
   input  logic [ADDR_WIDTH-1:0] ReadRegister2,
   output logic [DATA_WIDTH-1:0] ReadData1,
   output logic [DATA_WIDTH-1:0] ReadData2,
   output logic                  ReadPending1,
   output logic                  ReadPending2,
   output logic                  Hazard,
   input  logic [ADDR_WIDTH-1:0] WriteRegister,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic                  RegWrite,
   input  logic                  IssueValid,
   input  logic [ADDR_WIDTH-1:0] IssueRegister,
   output logic [ADDR_WIDTH:0]   PendingCount
);

   // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0] DepthLimit = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] CountOne   = (ADDR_WIDTH + 1)'(1);

   // An address is architecturally usable when it is inside the array and is
   // not the hard-wired zero register.
   function automatic logic isValid(input logic [ADDR_WIDTH-1:0] addr);
      return ({1'b0, addr} < DepthLimit) && !((ZERO_REG != 0) && (addr == '0));
   endfunction

   logic [DATA_WIDTH-1:0] regFile [DEPTH];
   logic [DEPTH-1:0]      pendingReg;
   logic [DEPTH-1:0]      pendingNext;
   logic [ADDR_WIDTH:0]   countReg;
   logic [ADDR_WIDTH:0]   countNext;

   logic                  writeEff;
   logic                  issueEff;
   logic [DEPTH-1:0]      writeHit;
   logic [DEPTH-1:0]      issueHit;
   logic                  countInc;
   logic                  countDec;

   assign writeEff = RegWrite & isValid(WriteRegister);
   assign issueEff = IssueValid & isValid(IssueRegister);

   // One-hot decode of the writeback and issue destinations.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : genHit
         localparam logic [ADDR_WIDTH-1:0] RegIdx = ADDR_WIDTH'(gi);
         assign writeHit[gi] = writeEff & (WriteRegister == RegIdx);
         assign issueHit[gi] = issueEff & (IssueRegister == RegIdx);
      end
   endgenerate

   // Clear first, then set: a new producer supersedes the retiring one.
   assign pendingNext = (pendingReg & ~writeHit) | issueHit;

   // With at most one issue and one retire per cycle the population changes
   // by at most one in each direction, so the count is tracked incrementally
   // instead of re-counting the whole vector.
   assign countInc = |(issueHit & ~pendingReg);
   assign countDec = |(writeHit & pendingReg & ~issueHit);

   always_comb begin
      countNext = countReg;
      if (countInc && !countDec) begin
         countNext = countReg + CountOne;
      end else if (countDec && !countInc) begin
         countNext = countReg - CountOne;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regFile[i] <= '0;
         end
         pendingReg <= '0;
         countReg   <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (writeHit[i]) begin
               regFile[i] <= WriteData;
            end
         end
         pendingReg <= pendingNext;
         countReg   <= countNext;
      end
   end

   assign PendingCount = countReg;

   // Read ports. The stored-value mux only covers implemented registers, so
   // addresses beyond DEPTH never index outside the arrays.
   logic [ADDR_WIDTH-1:0] rdAddr    [2];
   logic [DATA_WIDTH-1:0] rdData    [2];
   logic                  rdPending [2];

   assign rdAddr[0] = ReadRegister1;
   assign rdAddr[1] = ReadRegister2;

   generate
      for (gi = 0; gi < 2; gi++) begin : genRead
         logic [DATA_WIDTH-1:0] storedData;
         logic                  storedPend;
         logic                  addrValid;
         logic                  bypass;

         always_comb begin
            storedData = '0;
            storedPend = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
               if (rdAddr[gi] == ADDR_WIDTH'(i)) begin
                  storedData = regFile[i];
                  storedPend = pendingReg[i];
               end
            end
         end

         assign addrValid = isValid(rdAddr[gi]);
         // A retiring write both supplies the data and resolves the hazard.
         assign bypass    = writeEff & (WriteRegister == rdAddr[gi]);

         assign rdData[gi]    = !addrValid ? '0 : (bypass ? WriteData : storedData);
         assign rdPending[gi] = addrValid & storedPend & ~bypass;
      end
   endgenerate

   assign ReadData1    = rdData[0];
   assign ReadData2    = rdData[1];
   assign ReadPending1 = rdPending[0];
   assign ReadPending2 = rdPending[1];
   assign Hazard       = rdPending[0] | rdPending[1];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Bench for regfile_scoreboard. Three instances: default parameters, a copy
// with ZERO_REG=0, and a small 16-bit x 8 register copy with 4-bit addresses.
// Each test task drives stimulus, pushes the expected observation onto a
// queue, samples the DUT 2 time units later, and drains the queue at its end.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;

   typedef struct packed {
      logic [31:0] d1;
      logic [31:0] d2;
      logic        p1;
      logic        p2;
      logic        hz;
      logic [5:0]  cnt;
   } ObsT;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   always #5 Clk = ~Clk;

   // default instance
   logic [4:0]  rr1, rr2, wr, ir;
   logic [31:0] wd, rd1, rd2;
   logic        rw, iv, p1, p2, hz;
   logic [5:0]  cnt;

   // ZERO_REG=0 instance
   logic [4:0]  nzRr1, nzRr2, nzWr, nzIr;
   logic [31:0] nzWd, nzRd1, nzRd2;
   logic        nzRw, nzIv, nzP1, nzP2, nzHz;
   logic [5:0]  nzCnt;

   // small instance
   logic [3:0]  sRr1, sRr2, sWr, sIr;
   logic [15:0] sWd, sRd1, sRd2;
   logic        sRw, sIv, sP1, sP2, sHz;
   logic [4:0]  sCnt;

   regfile_scoreboard dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .ReadRegister1(rr1), .ReadRegister2(rr2),
      .ReadData1(rd1), .ReadData2(rd2),
      .ReadPending1(p1), .ReadPending2(p2), .Hazard(hz),
      .WriteRegister(wr), .WriteData(wd), .RegWrite(rw),
      .IssueValid(iv), .IssueRegister(ir), .PendingCount(cnt)
   );

   regfile_scoreboard #(.ZERO_REG(0)) dutNz (
      .Clk(Clk), .Reset_n(Reset_n),
      .ReadRegister1(nzRr1), .ReadRegister2(nzRr2),
      .ReadData1(nzRd1), .ReadData2(nzRd2),
      .ReadPending1(nzP1), .ReadPending2(nzP2), .Hazard(nzHz),
      .WriteRegister(nzWr), .WriteData(nzWd), .RegWrite(nzRw),
      .IssueValid(nzIv), .IssueRegister(nzIr), .PendingCount(nzCnt)
   );

   regfile_scoreboard #(.DATA_WIDTH(16), .DEPTH(8), .ADDR_WIDTH(4)) dutSmall (
      .Clk(Clk), .Reset_n(Reset_n),
      .ReadRegister1(sRr1), .ReadRegister2(sRr2),
      .ReadData1(sRd1), .ReadData2(sRd2),
      .ReadPending1(sP1), .ReadPending2(sP2), .Hazard(sHz),
      .WriteRegister(sWr), .WriteData(sWd), .RegWrite(sRw),
      .IssueValid(sIv), .IssueRegister(sIr), .PendingCount(sCnt)
   );

   int    total = 0;
   int    bad = 0;
   ObsT   expQ[$];
   ObsT   gotQ[$];
   string tagQ[$];

   function automatic ObsT mk(input logic [31:0] d1, input logic [31:0] d2,
                              input logic a1, input logic a2, input logic h,
                              input logic [5:0] c);
      ObsT o;
      o.d1 = d1; o.d2 = d2; o.p1 = a1; o.p2 = a2; o.hz = h; o.cnt = c;
      return o;
   endfunction

   function automatic ObsT obsMain();
      return mk(rd1, rd2, p1, p2, hz, cnt);
   endfunction

   function automatic ObsT obsNz();
      return mk(nzRd1, nzRd2, nzP1, nzP2, nzHz, nzCnt);
   endfunction

   function automatic ObsT obsSmall();
      return mk({16'h0, sRd1}, {16'h0, sRd2}, sP1, sP2, sHz, {1'b0, sCnt});
   endfunction

   function automatic string fmt(input ObsT o);
      return $sformatf("d1=%h d2=%h p1=%b p2=%b hz=%b cnt=%0d",
                       o.d1, o.d2, o.p1, o.p2, o.hz, o.cnt);
   endfunction

   task automatic expectObs(input string tag, input ObsT e);
      tagQ.push_back(tag);
      expQ.push_back(e);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idleAll();
      rr1 = 0; rr2 = 0; wr = 0; wd = 0; rw = 0; iv = 0; ir = 0;
      nzRr1 = 0; nzRr2 = 0; nzWr = 0; nzWd = 0; nzRw = 0; nzIv = 0; nzIr = 0;
      sRr1 = 0; sRr2 = 0; sWr = 0; sWd = 0; sRw = 0; sIv = 0; sIr = 0;
   endtask

   // -----------------------------------------------------------------------
   task automatic test_reset();
      rr1 = 5; rr2 = 0;
      expectObs("reset_state", mk(0, 0, 0, 0, 0, 0));
      #2 gotQ.push_back(obsMain());
      tick();
      // write reg5 and issue reg5 together: data lands, bit stays set
      rw = 1; wr = 5; wd = 32'hDEADBEEF; iv = 1; ir = 5;
      tick();
      rw = 0; iv = 0; rr1 = 5;
      expectObs("pre_reset", mk(32'hDEADBEEF, 0, 1, 0, 1, 1));
      #2 gotQ.push_back(obsMain());
      // a write in flight when reset hits must be lost
      rw = 1; wr = 6; wd = 32'hCAFEF00D;
      #1 Reset_n = 0;
      expectObs("async_reset", mk(0, 0, 0, 0, 0, 0));
      #1 gotQ.push_back(obsMain());
      tick();
      rw = 0; Reset_n = 1; rr1 = 6; rr2 = 5;
      expectObs("write_discarded", mk(0, 0, 0, 0, 0, 0));
      #2 gotQ.push_back(obsMain());
      tick();
      while (expQ.size() > 0) begin
         ObsT e = expQ.pop_front();
         ObsT g = gotQ.pop_front();
         string t = tagQ.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL %s: got %s expected %s", t, fmt(g), fmt(e));
         end else $display("check %s ok: %s", t, fmt(g));
      end
   endtask

   // -----------------------------------------------------------------------
   task automatic test_bypass();
      rw = 1; wr = 7; wd = 32'h12345678; rr1 = 7; rr2 = 7;
      expectObs("bypass_same_cycle", mk(32'h12345678, 32'h12345678, 0, 0, 0, 0));
      #2 gotQ.push_back(obsMain());
      tick();
      rw = 0; wd = 0;
      expectObs("reg7_after_edge", mk(32'h12345678, 32'h12345678, 0, 0, 0, 0));
      #2 gotQ.push_back(obsMain());
      tick();
      while (expQ.size() > 0) begin
         ObsT e = expQ.pop_front();
         ObsT g = gotQ.pop_front();
         string t = tagQ.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL %s: got %s expected %s", t, fmt(g), fmt(e));
         end else $display("check %s ok: %s", t, fmt(g));
      end
   endtask

   // -----------------------------------------------------------------------
   task automatic test_zero_reg();
      rw = 1; wr = 0; wd = 32'hFFFFFFFF; iv = 1; ir = 0; rr1 = 0; rr2 = 0;
      nzRw = 1; nzWr = 0; nzWd = 32'hFFFFFFFF; nzIv = 1; nzIr = 0; nzRr1 = 0; nzRr2 = 0;
      expectObs("zero_bypass_blocked", mk(0, 0, 0, 0, 0, 0));
      expectObs("nz_bypass", mk(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0));
      #2 gotQ.push_back(obsMain());
      gotQ.push_back(obsNz());
      tick();
      rw = 0; iv = 0; nzRw = 0; nzIv = 0;
      expectObs("zero_after_edge", mk(0, 0, 0, 0, 0, 0));
      expectObs("nz_reg0_pending", mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 1, 1));
      #2 gotQ.push_back(obsMain());
      gotQ.push_back(obsNz());
      tick();
      // retire reg0 on the ZERO_REG=0 copy
      nzRw = 1; nzWd = 32'h0000ABCD;
      tick();
      nzRw = 0;
      expectObs("nz_reg0_retired", mk(32'h0000ABCD, 32'h0000ABCD, 0, 0, 0, 0));
      #2 gotQ.push_back(obsNz());
      tick();
      while (expQ.size() > 0) begin
         ObsT e = expQ.pop_front();
         ObsT g = gotQ.pop_front();
         string t = tagQ.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL %s: got %s expected %s", t, fmt(g), fmt(e));
         end else $display("check %s ok: %s", t, fmt(g));
      end
   endtask

   // -----------------------------------------------------------------------
   task automatic test_lifecycle();
      iv = 1; ir = 3; rr1 = 3; rr2 = 7;
      expectObs("issue_same_cycle", mk(0, 32'h12345678, 0, 0, 0, 0));
      #2 gotQ.push_back(obsMain());
      tick();
      iv = 0;
      expectObs("pending_after_issue", mk(0, 32'h12345678, 1, 0, 1, 1));
      #2 gotQ.push_back(obsMain());
      tick();
      rw = 1; wr = 3; wd = 32'hAAAA5555;
      expectObs("retire_bypass", mk(32'hAAAA5555, 32'h12345678, 0, 0, 0, 1));
      #2 gotQ.push_back(obsMain());
      tick();
      rw = 0;
      expectObs("retired", mk(32'hAAAA5555, 32'h12345678, 0, 0, 0, 0));
      #2 gotQ.push_back(obsMain());
      tick();
      while (expQ.size() > 0) begin
         ObsT e = expQ.pop_front();
         ObsT g = gotQ.pop_front();
         string t = tagQ.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL %s: got %s expected %s", t, fmt(g), fmt(e));
         end else $display("check %s ok: %s", t, fmt(g));
      end
   endtask

   // -----------------------------------------------------------------------
   task automatic test_simultaneous();
      iv = 1; ir = 4;
      tick();
      // set and clear reg4 in one cycle
      iv = 1; ir = 4; rw = 1; wr = 4; wd = 32'h44; rr1 = 4; rr2 = 9;
      expectObs("set_clear_same_pre", mk(32'h44, 0, 0, 0, 0, 1));
      #2 gotQ.push_back(obsMain());
      tick();
      iv = 0; rw = 0;
      expectObs("set_wins", mk(32'h44, 0, 1, 0, 1, 1));
      #2 gotQ.push_back(obsMain());
      tick();
      // issue reg9 while reg4 retires
      iv = 1; ir = 9; rw = 1; wr = 4; wd = 32'h55;
      expectObs("issue9_retire4_pre", mk(32'h55, 0, 0, 0, 0, 1));
      #2 gotQ.push_back(obsMain());
      tick();
      // re-issue of an already pending register changes nothing
      iv = 1; ir = 9; rw = 0;
      expectObs("issue9_retire4", mk(32'h55, 0, 0, 1, 1, 1));
      #2 gotQ.push_back(obsMain());
      tick();
      iv = 0;
      expectObs("reissue_no_change", mk(32'h55, 0, 0, 1, 1, 1));
      #2 gotQ.push_back(obsMain());
      rw = 1; wr = 9; wd = 32'h99;
      tick();
      rw = 0;
      expectObs("cleanup9", mk(32'h55, 32'h99, 0, 0, 0, 0));
      #2 gotQ.push_back(obsMain());
      tick();
      while (expQ.size() > 0) begin
         ObsT e = expQ.pop_front();
         ObsT g = gotQ.pop_front();
         string t = tagQ.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL %s: got %s expected %s", t, fmt(g), fmt(e));
         end else $display("check %s ok: %s", t, fmt(g));
      end
   endtask

   // -----------------------------------------------------------------------
   task automatic test_params();
      sRw = 1; sWr = 12; sWd = 16'hBEEF; sIv = 1; sIr = 12; sRr1 = 12; sRr2 = 12;
      expectObs("small_invalid_bypass", mk(0, 0, 0, 0, 0, 0));
      #2 gotQ.push_back(obsSmall());
      tick();
      sRw = 0; sIv = 0;
      expectObs("small_invalid_after", mk(0, 0, 0, 0, 0, 0));
      #2 gotQ.push_back(obsSmall());
      for (int k = 1; k <= 7; k++) begin
         sIv = 1; sIr = 4'(k);
         tick();
      end
      sIv = 0; sRr1 = 7; sRr2 = 1;
      expectObs("small_all_pending", mk(0, 0, 1, 1, 1, 7));
      #2 gotQ.push_back(obsSmall());
      tick();
      sIv = 1; sIr = 3;
      tick();
      sIv = 0;
      expectObs("small_saturated", mk(0, 0, 1, 1, 1, 7));
      #2 gotQ.push_back(obsSmall());
      sRw = 1; sWr = 7; sWd = 16'h1234;
      tick();
      sRw = 0;
      expectObs("small_retire7", mk(32'h1234, 0, 0, 1, 1, 6));
      #2 gotQ.push_back(obsSmall());
      tick();
      while (expQ.size() > 0) begin
         ObsT e = expQ.pop_front();
         ObsT g = gotQ.pop_front();
         string t = tagQ.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL %s: got %s expected %s", t, fmt(g), fmt(e));
         end else $display("check %s ok: %s", t, fmt(g));
      end
   endtask

   // -----------------------------------------------------------------------
   // Random traffic on the default instance against a behavioural model.
   task automatic test_back_to_back();
      logic [31:0] mReg  [32];
      logic        mPend [32];
      int          mCnt;
      ObsT         e;
      Reset_n = 0;
      #2 Reset_n = 1;
      for (int i = 0; i < 32; i++) begin
         mReg[i] = 0; mPend[i] = 0;
      end
      mCnt = 0;
      tick();
      for (int n = 0; n < 150; n++) begin
         rr1 = 5'($urandom_range(0, 7));
         rr2 = 5'($urandom_range(0, 31));
         wr  = 5'($urandom_range(0, 7));
         ir  = 5'($urandom_range(0, 7));
         wd  = $urandom;
         rw  = 1'($urandom_range(0, 1));
         iv  = 1'($urandom_range(0, 1));
         e.d1 = (rr1 == 0) ? 32'h0 : ((rw && wr == rr1) ? wd : mReg[rr1]);
         e.d2 = (rr2 == 0) ? 32'h0 : ((rw && wr == rr2) ? wd : mReg[rr2]);
         e.p1 = (rr1 != 0) && mPend[rr1] && !(rw && wr == rr1);
         e.p2 = (rr2 != 0) && mPend[rr2] && !(rw && wr == rr2);
         e.hz = e.p1 | e.p2;
         e.cnt = 6'(mCnt);
         expectObs($sformatf("rand_%0d", n), e);
         #2 gotQ.push_back(obsMain());
         if (rw && wr != 0) begin
            mReg[wr] = wd;
            mPend[wr] = 0;
         end
         if (iv && ir != 0) mPend[ir] = 1;
         mCnt = 0;
         for (int i = 0; i < 32; i++) mCnt += int'(mPend[i]);
         tick();
      end
      idleAll();
      while (expQ.size() > 0) begin
         ObsT ex = expQ.pop_front();
         ObsT g = gotQ.pop_front();
         string t = tagQ.pop_front();
         total++;
         if (g !== ex) begin
            bad++;
            $display("FAIL %s: got %s expected %s", t, fmt(g), fmt(ex));
         end else $display("check %s ok: %s", t, fmt(g));
      end
   endtask

   initial begin
      idleAll();
      Reset_n = 0;
      #12 Reset_n = 1;
      tick();
      test_reset();
      test_bypass();
      test_zero_reg();
      test_lifecycle();
      test_simultaneous();
      test_params();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
